mont_exp_core: RTL and testbench

MONT_EXP_CORE -- requirements
Module: mont_exp_core

---
 rtl/mont_exp_core.sv | 161 ++++++++++++++++
 tb/tb_mont_exp_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_core.sv
// Modular exponentiation a^e mod n: right-to-left binary scan, radix-2 Montgomery products (ans, t squared in parallel).
// Latency 1 + (WIDTH+1) + K*(WIDTH+1) cycles from accepted i_start; single operation in flight, i_start outside IDLE is dropped.
module mont_exp_core #(
   parameter int WIDTH      = 256,
   parameter int EARLY_EXIT = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_e,
   input  logic [WIDTH-1:0] i_n,
   output logic [WIDTH-1:0] o_result,
   output logic             o_busy,
   output logic             o_finished,
   output logic             o_error
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, PREP, LOOP, COMMIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] n_q, e_q, t_q, ans_q, x1_q, x2_q, result_q;
   logic [WIDTH+1:0] u1_q, u2_q;
   logic [CW-1:0]    cnt_q, k_q;
   logic             err_q;

   logic             accept, reject, busy, prep_last, loop_last, commit_last, zero_bits;
   logic [WIDTH:0]   dbl_raw;
   logic [WIDTH-1:0] dbl, u1_red, u2_red, ans_new, ans_fin, fin_val;
   logic [WIDTH+1:0] s1, s2, u1_nxt, u2_nxt;

   // Operand screening and loop-control conditions
   always_comb begin
      reject    = ~i_n[0] | (i_a >= i_n);
      accept    = i_start & ~i_abort;
      busy      = (state_q == PREP) || (state_q == LOOP) || (state_q == COMMIT);
      prep_last = (cnt_q == CW'(WIDTH));
      loop_last = (cnt_q == CW'(WIDTH - 1));
      // With early exit, e_q is shifted right per bit, so "remaining bits all zero" marks the top set bit
      if (EARLY_EXIT != 0) begin
         commit_last = (e_q[WIDTH-1:1] == '0);
         zero_bits   = (e_q == '0);
      end else begin
         commit_last = (k_q == CW'(WIDTH - 1));
         zero_bits   = 1'b0;
      end
   end

   // Datapath arithmetic: modular doubling for t = a*2^WIDTH, two Montgomery steps, final reductions
   always_comb begin
      dbl_raw = {t_q, 1'b0};
      dbl     = (dbl_raw >= {1'b0, n_q}) ? WIDTH'(dbl_raw - {1'b0, n_q}) : dbl_raw[WIDTH-1:0];

      s1 = u1_q + (x1_q[0] ? {2'b00, t_q} : '0);
      if (s1[0]) s1 = s1 + {2'b00, n_q};
      u1_nxt = s1 >> 1;

      s2 = u2_q + (x2_q[0] ? {2'b00, t_q} : '0);
      if (s2[0]) s2 = s2 + {2'b00, n_q};
      u2_nxt = s2 >> 1;

      u1_red  = (u1_q >= {2'b00, n_q}) ? WIDTH'(u1_q - {2'b00, n_q}) : u1_q[WIDTH-1:0];
      u2_red  = (u2_q >= {2'b00, n_q}) ? WIDTH'(u2_q - {2'b00, n_q}) : u2_q[WIDTH-1:0];
      ans_new = e_q[0] ? u1_red : ans_q;
      ans_fin = (state_q == PREP) ? ans_q : ans_new;
      // ans may still be the initial 1 when no multiply happened, which must read as 0 for n == 1
      fin_val = (state_q == IDLE) ? '0 : ((ans_fin >= n_q) ? ans_fin - n_q : ans_fin);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = reject ? DONE : PREP;
         PREP:    if (prep_last) state_d = zero_bits ? DONE : LOOP;
         LOOP:    if (loop_last) state_d = COMMIT;
         COMMIT:  state_d = commit_last ? DONE : LOOP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (busy && i_abort) state_d = IDLE;
   end

   always_comb begin
      o_busy     = busy;
      o_finished = (state_q == DONE);
      o_error    = (state_q == DONE) && err_q;
      o_result   = result_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         n_q      <= '0;
         e_q      <= '0;
         t_q      <= '0;
         ans_q    <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         u1_q     <= '0;
         u2_q     <= '0;
         cnt_q    <= '0;
         k_q      <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         if (state_d == DONE) result_q <= fin_val;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  n_q   <= i_n;
                  e_q   <= i_e;
                  t_q   <= i_a;
                  ans_q <= WIDTH'(1);
                  cnt_q <= '0;
                  k_q   <= '0;
                  err_q <= reject;
               end
            end
            PREP: begin
               cnt_q <= cnt_q + CW'(1);
               if (!prep_last) begin
                  t_q <= dbl;
               end else begin
                  cnt_q <= '0;
                  u1_q  <= '0;
                  u2_q  <= '0;
                  x1_q  <= ans_q;
                  x2_q  <= t_q;
               end
            end
            LOOP: begin
               cnt_q <= cnt_q + CW'(1);
               x1_q  <= x1_q >> 1;
               x2_q  <= x2_q >> 1;
               if (e_q[0]) u1_q <= u1_nxt;
               u2_q  <= u2_nxt;
            end
            COMMIT: begin
               t_q   <= u2_red;
               ans_q <= ans_new;
               x1_q  <= ans_new;
               x2_q  <= u2_red;
               u1_q  <= '0;
               u2_q  <= '0;
               cnt_q <= '0;
               k_q   <= k_q + CW'(1);
               e_q   <= e_q >> 1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_exp_core.sv
// Directed bench for mont_exp_core: two WIDTH=8 instances (EARLY_EXIT 0/1) and one WIDTH=256 instance vs a reference model.
module tb_mont_exp_core;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, st0, st1, st2, abort;
   logic [7:0]   a8, e8, n8, r0, r1;
   logic         b0, f0, er0, b1, f1, er1;
   logic [255:0] a256, e256, n256, r2;
   logic         b2, f2, er2;
   int           n_checks = 0;
   int           n_fail = 0;

   mont_exp_core #(.WIDTH(8), .EARLY_EXIT(0)) d0 (
      .i_clk(clk), .i_rst(rst), .i_start(st0), .i_abort(abort),
      .i_a(a8), .i_e(e8), .i_n(n8),
      .o_result(r0), .o_busy(b0), .o_finished(f0), .o_error(er0));

   mont_exp_core #(.WIDTH(8), .EARLY_EXIT(1)) d1 (
      .i_clk(clk), .i_rst(rst), .i_start(st1), .i_abort(abort),
      .i_a(a8), .i_e(e8), .i_n(n8),
      .o_result(r1), .o_busy(b1), .o_finished(f1), .o_error(er1));

   mont_exp_core #(.WIDTH(256), .EARLY_EXIT(1)) d2 (
      .i_clk(clk), .i_rst(rst), .i_start(st2), .i_abort(abort),
      .i_a(a256), .i_e(e256), .i_n(n256),
      .o_result(r2), .o_busy(b2), .o_finished(f2), .o_error(er2));

   function automatic logic [255:0] ref_modexp(input logic [255:0] a, input logic [255:0] e,
                                                input logic [255:0] n);
      logic [511:0] r, b, m;
      m = {256'd0, n};
      r = 512'd1 % m;
      b = {256'd0, a};
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = (r * b) % m;
         b = (b * b) % m;
      end
      return r[255:0];
   endfunction

   // Pulse start for one cycle (cycle 0), then scramble operands; returns just after the accepting edge
   task automatic start8(input int which, input logic [7:0] a, input logic [7:0] e, input logic [7:0] n);
      @(posedge clk); #1;
      a8 = a; e8 = e; n8 = n;
      if (which == 0) st0 = 1'b1; else st1 = 1'b1;
      @(posedge clk); #1;
      st0 = 1'b0; st1 = 1'b0;
      a8 = 8'hA5; e8 = 8'h5A; n8 = 8'h3C;
   endtask

   // Returns the cycle index of o_finished, or budget+1 on timeout
   task automatic wait_fin(input int which, input int first, input int budget, output int cyc);
      int   c;
      logic f;
      cyc = budget + 1;
      c = first;
      while (c <= budget && cyc > budget) begin
         @(negedge clk);
         f = (which == 0) ? f0 : (which == 1) ? f1 : f2;
         if (f) cyc = c;
         c++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; abort = 1'b0;
      a8 = '0; e8 = '0; n8 = '0; a256 = '0; e256 = '0; n256 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({r0, b0, f0, er0} !== 11'd0) begin
         n_fail++; $display("FAIL reset_d0: got %b expected all zero", {r0, b0, f0, er0});
      end
      n_checks++;
      if ({r1, b1, f1, er1} !== 11'd0) begin
         n_fail++; $display("FAIL reset_d1: got %b expected all zero", {r1, b1, f1, er1});
      end
      n_checks++;
      if ({r2, b2, f2, er2} !== 259'd0) begin
         n_fail++; $display("FAIL reset_d2: got %h expected all zero", {r2, b2, f2, er2});
      end
   endtask

   task automatic test_zero_exp;
      int cyc;
      start8(0, 8'd0, 8'd0, 8'd1);
      wait_fin(0, 1, 200, cyc);
      n_checks++;
      if (cyc !== 82) begin n_fail++; $display("FAIL zexp_n1_latency: got %0d expected 82", cyc); end
      n_checks++;
      if (r0 !== 8'd0) begin n_fail++; $display("FAIL zexp_n1_result: got %0d expected 0", r0); end
      start8(0, 8'd3, 8'd0, 8'd7);
      wait_fin(0, 1, 200, cyc);
      n_checks++;
      if (r0 !== 8'd1) begin n_fail++; $display("FAIL zexp_n7_result: got %0d expected 1", r0); end
      start8(1, 8'd0, 8'd0, 8'd1);
      wait_fin(1, 1, 200, cyc);
      n_checks++;
      if (cyc !== 10) begin n_fail++; $display("FAIL zexp_ee_latency: got %0d expected 10", cyc); end
      n_checks++;
      if (r1 !== 8'd0) begin n_fail++; $display("FAIL zexp_ee_n1_result: got %0d expected 0", r1); end
      start8(1, 8'd3, 8'd0, 8'd7);
      wait_fin(1, 1, 200, cyc);
      n_checks++;
      if (r1 !== 8'd1) begin n_fail++; $display("FAIL zexp_ee_n7_result: got %0d expected 1", r1); end
   endtask

   task automatic test_reject;
      int cyc;
      start8(0, 8'd3, 8'd5, 8'd8);
      wait_fin(0, 1, 50, cyc);
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL reject_even_latency: got %0d expected 1", cyc); end
      n_checks++;
      if (er0 !== 1'b1) begin n_fail++; $display("FAIL reject_even_error: got %b expected 1", er0); end
      n_checks++;
      if (r0 !== 8'd0) begin n_fail++; $display("FAIL reject_even_result: got %0d expected 0", r0); end
      start8(0, 8'd9, 8'd5, 8'd7);
      wait_fin(0, 1, 50, cyc);
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL reject_a_ge_n_latency: got %0d expected 1", cyc); end
      n_checks++;
      if (er0 !== 1'b1) begin n_fail++; $display("FAIL reject_a_ge_n_error: got %b expected 1", er0); end
      @(negedge clk);
      n_checks++;
      if ({f0, er0} !== 2'b00) begin n_fail++; $display("FAIL reject_pulse_width: got %b expected 00", {f0, er0}); end
   endtask

   task automatic test_basic;
      int cyc;
      start8(0, 8'd3, 8'd5, 8'd7);
      @(negedge clk);
      n_checks++;
      if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", b0); end
      wait_fin(0, 2, 200, cyc);
      n_checks++;
      if (cyc !== 82) begin n_fail++; $display("FAIL basic_latency: got %0d expected 82", cyc); end
      n_checks++;
      if (r0 !== 8'd5) begin n_fail++; $display("FAIL basic_result: got %0d expected 5", r0); end
      n_checks++;
      if (er0 !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", er0); end
      @(negedge clk);
      n_checks++;
      if ({r0, b0, f0} !== {8'd5, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL basic_hold: got %h expected %h", {r0, b0, f0}, {8'd5, 2'b00});
      end
   endtask

   task automatic test_early_exit;
      int cyc;
      start8(1, 8'd2, 8'd10, 8'd11);
      wait_fin(1, 1, 200, cyc);
      n_checks++;
      if (cyc !== 46) begin n_fail++; $display("FAIL ee_latency: got %0d expected 46", cyc); end
      n_checks++;
      if (r1 !== 8'd1) begin n_fail++; $display("FAIL ee_result: got %0d expected 1", r1); end
      n_checks++;
      if (er1 !== 1'b0) begin n_fail++; $display("FAIL ee_error: got %b expected 0", er1); end
   endtask

   task automatic test_abort;
      int   cyc;
      logic saw;
      start8(0, 8'd4, 8'd3, 8'd7);
      repeat (19) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      n_checks++;
      if (b0 !== 1'b1) begin n_fail++; $display("FAIL abort_busy_c20: got %b expected 1", b0); end
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b0 !== 1'b0) begin n_fail++; $display("FAIL abort_busy_c21: got %b expected 0", b0); end
      saw = 1'b0;
      repeat (100) begin @(negedge clk); if (f0) saw = 1'b1; end
      n_checks++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_finish: got %b expected 0", saw); end
      n_checks++;
      if (r0 !== 8'd5) begin n_fail++; $display("FAIL abort_result_kept: got %0d expected 5", r0); end
      start8(0, 8'd4, 8'd3, 8'd7);
      wait_fin(0, 1, 200, cyc);
      n_checks++;
      if (cyc !== 82) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 82", cyc); end
      n_checks++;
      if (r0 !== 8'd1) begin n_fail++; $display("FAIL abort_restart_result: got %0d expected 1", r0); end
   endtask

   task automatic test_ignore;
      int   cyc;
      logic saw;
      @(posedge clk); #1;
      a8 = 8'd3; e8 = 8'd5; n8 = 8'd7; st1 = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      st1 = 1'b0; abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b1 !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy: got %b expected 0", b1); end
      saw = 1'b0;
      repeat (60) begin @(negedge clk); if (f1) saw = 1'b1; end
      n_checks++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_start_no_finish: got %b expected 0", saw); end
      start8(1, 8'd3, 8'd5, 8'd7);
      repeat (9) @(posedge clk);
      #1 a8 = 8'd2; e8 = 8'd10; n8 = 8'd11; st1 = 1'b1;
      @(posedge clk);
      #1 st1 = 1'b0;
      wait_fin(1, 11, 200, cyc);
      n_checks++;
      if (cyc !== 37) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 37", cyc); end
      n_checks++;
      if (r1 !== 8'd5) begin n_fail++; $display("FAIL busy_start_result: got %0d expected 5", r1); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      start8(1, 8'd2, 8'd10, 8'd11);
      wait_fin(1, 1, 200, cyc);
      n_checks++;
      if (r1 !== 8'd1) begin n_fail++; $display("FAIL b2b_first_result: got %0d expected 1", r1); end
      start8(1, 8'd3, 8'd5, 8'd7);
      wait_fin(1, 1, 200, cyc);
      n_checks++;
      if (cyc !== 37) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 37", cyc); end
      n_checks++;
      if (r1 !== 8'd5) begin n_fail++; $display("FAIL b2b_second_result: got %0d expected 5", r1); end
   endtask

   task automatic test_w256;
      logic [255:0] a, e, n, expv;
      int           k, lat, cyc;
      for (int it = 0; it < 40; it++) begin
         for (int w = 0; w < 8; w++) n[w*32 +: 32] = $urandom;
         n[0] = 1'b1;
         if (it % 2 == 0) n[255] = 1'b1;
         for (int w = 0; w < 8; w++) a[w*32 +: 32] = $urandom;
         a = a % n;
         if (it == 0) a = n - 256'd1;
         e = 256'($urandom_range(0, 15));
         if (it == 1) e = 256'd0;
         if (it == 2) e = 256'd15;
         k = 0;
         for (int i = 0; i < 256; i++) if (e[i]) k = i + 1;
         lat = 1 + 257 + k * 257;
         expv = ref_modexp(a, e, n);
         @(posedge clk); #1;
         a256 = a; e256 = e; n256 = n; st2 = 1'b1;
         @(posedge clk); #1;
         st2 = 1'b0; a256 = ~a; e256 = ~e;
         wait_fin(2, 1, lat + 20, cyc);
         n_checks++;
         if (cyc !== lat) begin n_fail++; $display("FAIL w256_latency[%0d]: got %0d expected %0d", it, cyc, lat); end
         n_checks++;
         if (r2 !== expv) begin n_fail++; $display("FAIL w256_result[%0d]: got %h expected %h", it, r2, expv); end
         n_checks++;
         if (er2 !== 1'b0) begin n_fail++; $display("FAIL w256_error[%0d]: got %b expected 0", it, er2); end
      end
   endtask

   task automatic test_reset_mid;
      logic saw;
      int   w;
      w = $urandom_range(20, 1000);
      @(posedge clk); #1;
      n256 = {256{1'b1}}; a256 = n256 - 256'd2; e256 = 256'd15; st2 = 1'b1;
      @(posedge clk); #1;
      st2 = 1'b0;
      repeat (w) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (b2 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", b2); end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({r2, b2, f2, er2} !== 259'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got %h expected all zero", {r2, b2, f2, er2});
      end
      saw = 1'b0;
      repeat (1400) begin @(negedge clk); if (f2) saw = 1'b1; end
      n_checks++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_finish: got %b expected 0", saw); end
   endtask

   initial begin
      test_reset;
      test_zero_exp;
      test_reject;
      test_basic;
      test_early_exit;
      test_abort;
      test_ignore;
      test_back_to_back;
      test_w256;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
